// File: rtl/issue_queue_sched.sv
// Single-issue, oldest-first scheduler for a 16-entry issue queue with tag wakeup.
// Optional IQ_WAKEUP_BYPASS_EN: same-cycle wakeup feeds selection (zero-cycle wakeup-to-issue).
module iq_entry #(
  parameter int OPCODE_WIDTH  = 7,
  parameter int TAG_WIDTH     = 6,
  parameter int AGE_WIDTH     = 5,
  parameter int PAYLOAD_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr,
  input  logic                     clr,
  input  logic                     dec,
  input  logic [OPCODE_WIDTH-1:0]  wr_op,
  input  logic [TAG_WIDTH-1:0]     wr_src1_tag,
  input  logic [TAG_WIDTH-1:0]     wr_src2_tag,
  input  logic                     wr_src1_rdy,
  input  logic                     wr_src2_rdy,
  input  logic [TAG_WIDTH-1:0]     wr_dst_tag,
  input  logic [PAYLOAD_WIDTH-1:0] wr_payload,
  input  logic [AGE_WIDTH-1:0]     wr_age,
  input  logic                     wakeup_valid,
  input  logic [TAG_WIDTH-1:0]     wakeup_tag,
  output logic                     valid,
  output logic                     ready,
  output logic [OPCODE_WIDTH-1:0]  op,
  output logic [TAG_WIDTH-1:0]     dst_tag,
  output logic [PAYLOAD_WIDTH-1:0] payload,
  output logic [AGE_WIDTH-1:0]     age
);
  logic [TAG_WIDTH-1:0] src1_tag, src2_tag;
  logic                 rdy1, rdy2, wk1, wk2;

  assign wk1 = wakeup_valid && (src1_tag == wakeup_tag);
  assign wk2 = wakeup_valid && (src2_tag == wakeup_tag);

`ifdef IQ_WAKEUP_BYPASS_EN
  assign ready = valid && (rdy1 || wk1) && (rdy2 || wk2);
`else
  assign ready = valid && rdy1 && rdy2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      rdy1     <= 1'b0;
      rdy2     <= 1'b0;
      op       <= '0;
      src1_tag <= '0;
      src2_tag <= '0;
      dst_tag  <= '0;
      payload  <= '0;
      age      <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid    <= 1'b1;
      rdy1     <= wr_src1_rdy;
      rdy2     <= wr_src2_rdy;
      op       <= wr_op;
      src1_tag <= wr_src1_tag;
      src2_tag <= wr_src2_tag;
      dst_tag  <= wr_dst_tag;
      payload  <= wr_payload;
      age      <= wr_age;
    end else begin
      if (clr)         valid <= 1'b0;
      if (valid && wk1) rdy1 <= 1'b1;
      if (valid && wk2) rdy2 <= 1'b1;
      if (dec)         age  <= age - 1'b1;
    end
  end
endmodule

module issue_queue_sched #(
  parameter int DEPTH         = 16,
  parameter int OPCODE_WIDTH  = 7,
  parameter int TAG_WIDTH     = 6,
  parameter int AGE_WIDTH     = 5,
  parameter int PAYLOAD_WIDTH = 32,
  localparam int IDXW         = $clog2(DEPTH),
  localparam int CNTW         = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OPCODE_WIDTH-1:0]  disp_op,
  input  logic [TAG_WIDTH-1:0]     disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]     disp_src2_tag,
  input  logic                     disp_src1_rdy,
  input  logic                     disp_src2_rdy,
  input  logic [TAG_WIDTH-1:0]     disp_dst_tag,
  input  logic [PAYLOAD_WIDTH-1:0] disp_payload,
  input  logic                     wakeup_valid,
  input  logic [TAG_WIDTH-1:0]     wakeup_tag,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OPCODE_WIDTH-1:0]  issue_op,
  output logic [TAG_WIDTH-1:0]     issue_dst_tag,
  output logic [PAYLOAD_WIDTH-1:0] issue_payload,
  output logic [IDXW-1:0]          issue_idx,
  output logic [CNTW-1:0]          count
);
  logic [DEPTH-1:0]                    ent_valid, ent_rdy, ent_wr, ent_clr, ent_dec;
  logic [DEPTH-1:0][OPCODE_WIDTH-1:0]  ent_op;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]     ent_dst;
  logic [DEPTH-1:0][PAYLOAD_WIDTH-1:0] ent_pay;
  logic [DEPTH-1:0][AGE_WIDTH-1:0]     ent_age;

  logic                 disp_fire, iss_fire, sel_found;
  logic [IDXW-1:0]      sel_idx, free_idx;
  logic [AGE_WIDTH-1:0] sel_age, new_age;
  logic                 byp1, byp2;

  assign disp_ready = (count != CNTW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = sel_found && issue_ready;
  assign new_age    = AGE_WIDTH'(count) - AGE_WIDTH'(iss_fire);
  // A dispatching op whose source is being broadcast right now must not miss it.
  assign byp1       = disp_src1_rdy || (wakeup_valid && disp_src1_tag == wakeup_tag);
  assign byp2       = disp_src2_rdy || (wakeup_valid && disp_src2_tag == wakeup_tag);

  // Ages are unique among valid entries, so the minimum is a single entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_rdy[i] && (!sel_found || ent_age[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
        sel_age   = ent_age[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent_valid[i]) free_idx = IDXW'(i);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_wr[i]  = disp_fire && (free_idx == IDXW'(i));
      ent_clr[i] = iss_fire && (sel_idx == IDXW'(i));
      ent_dec[i] = iss_fire && ent_valid[i] && (ent_age[i] > sel_age);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    iq_entry #(
      .OPCODE_WIDTH (OPCODE_WIDTH),
      .TAG_WIDTH    (TAG_WIDTH),
      .AGE_WIDTH    (AGE_WIDTH),
      .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
    ) u_ent (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr           (ent_wr[g]),
      .clr          (ent_clr[g]),
      .dec          (ent_dec[g]),
      .wr_op        (disp_op),
      .wr_src1_tag  (disp_src1_tag),
      .wr_src2_tag  (disp_src2_tag),
      .wr_src1_rdy  (byp1),
      .wr_src2_rdy  (byp2),
      .wr_dst_tag   (disp_dst_tag),
      .wr_payload   (disp_payload),
      .wr_age       (new_age),
      .wakeup_valid (wakeup_valid),
      .wakeup_tag   (wakeup_tag),
      .valid        (ent_valid[g]),
      .ready        (ent_rdy[g]),
      .op           (ent_op[g]),
      .dst_tag      (ent_dst[g]),
      .payload      (ent_pay[g]),
      .age          (ent_age[g])
    );
  end

  assign issue_valid   = sel_found;
  assign issue_idx     = sel_found ? sel_idx : '0;
  assign issue_op      = sel_found ? ent_op[sel_idx]  : '0;
  assign issue_dst_tag = sel_found ? ent_dst[sel_idx] : '0;
  assign issue_payload = sel_found ? ent_pay[sel_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count <= '0;
    else if (flush)                 count <= '0;
    else if (disp_fire && !iss_fire) count <= count + 1'b1;
    else if (iss_fire && !disp_fire) count <= count - 1'b1;
  end
endmodule

// File: tb/tb_issue_queue_sched.sv
// Bench for issue_queue_sched: directed vector table, hand sequences, and random
// traffic checked against an oldest-first list model.
module tb_issue_queue_sched;
`ifdef IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, disp_valid, disp_ready;
  logic [6:0]  disp_op, issue_op;
  logic [5:0]  disp_src1_tag, disp_src2_tag, disp_dst_tag, wakeup_tag, issue_dst_tag;
  logic        disp_src1_rdy, disp_src2_rdy, wakeup_valid, issue_valid, issue_ready;
  logic [31:0] disp_payload, issue_payload;
  logic [3:0]  issue_idx;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_queue_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .disp_payload(disp_payload),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
    .issue_payload(issue_payload), .issue_idx(issue_idx), .count(count)
  );

  // Model: slot contents plus a list of slot indices ordered oldest first.
  bit          mv[16], mr1[16], mr2[16];
  logic [6:0]  mop[16];
  logic [5:0]  ms1[16], ms2[16], mdst[16];
  logic [31:0] mpay[16];
  int          ord[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_rdy(input int i);
    bit w1, w2;
    w1 = BYP && wakeup_valid && (ms1[i] == wakeup_tag);
    w2 = BYP && wakeup_valid && (ms2[i] == wakeup_tag);
    return mv[i] && (mr1[i] || w1) && (mr2[i] || w2);
  endfunction

  function automatic int m_sel_pos();
    for (int k = 0; k < ord.size(); k++)
      if (m_rdy(ord[k])) return k;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    ord.delete();
  endtask

  task automatic compare_model();
    int p, s;
    p = m_sel_pos();
    s = (p < 0) ? -1 : ord[p];
    chk("m_count", count, 64'(ord.size()));
    chk("m_disp_ready", disp_ready, 64'(ord.size() != 16));
    chk("m_issue_valid", issue_valid, 64'(p >= 0));
    chk("m_issue_idx", issue_idx, (s < 0) ? 64'd0 : 64'(s));
    chk("m_issue_op", issue_op, (s < 0) ? 64'd0 : 64'(mop[s]));
    chk("m_issue_dst", issue_dst_tag, (s < 0) ? 64'd0 : 64'(mdst[s]));
    chk("m_issue_pay", issue_payload, (s < 0) ? 64'd0 : 64'(mpay[s]));
  endtask

  task automatic model_update();
    int p, fi;
    bit df;
    if (flush) begin m_clear(); return; end
    p  = m_sel_pos();
    df = disp_valid && ord.size() < 16;
    fi = -1;
    for (int i = 15; i >= 0; i--) if (!mv[i]) fi = i;
    if (wakeup_valid)
      for (int i = 0; i < 16; i++) if (mv[i]) begin
        if (ms1[i] == wakeup_tag) mr1[i] = 1;
        if (ms2[i] == wakeup_tag) mr2[i] = 1;
      end
    if (p >= 0 && issue_ready) begin
      mv[ord[p]] = 0;
      ord.delete(p);
    end
    if (df) begin
      mv[fi] = 1; mop[fi] = disp_op; ms1[fi] = disp_src1_tag; ms2[fi] = disp_src2_tag;
      mr1[fi] = disp_src1_rdy || (wakeup_valid && disp_src1_tag == wakeup_tag);
      mr2[fi] = disp_src2_rdy || (wakeup_valid && disp_src2_tag == wakeup_tag);
      mdst[fi] = disp_dst_tag; mpay[fi] = disp_payload;
      ord.push_back(fi);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; wakeup_valid = 0; issue_ready = 0;
  endtask

  task automatic drive_disp(input logic [6:0] op, input logic [5:0] t1, input bit r1,
                            input logic [5:0] t2, input bit r2);
    disp_valid = 1; disp_op = op; disp_src1_tag = t1; disp_src1_rdy = r1;
    disp_src2_tag = t2; disp_src2_rdy = r2;
    disp_dst_tag = 6'(op + 7'd8); disp_payload = 32'hA000_0000 | 32'(op);
  endtask

  // Expectations are for the outputs seen during the row's cycle, before its edge.
  typedef struct {
    bit fl; bit dv; logic [6:0] op; logic [5:0] t1; bit r1; logic [5:0] t2; bit r2;
    bit wv; logic [5:0] wt; bit ir;
    bit e_iv; logic [3:0] e_idx; logic [4:0] e_cnt; bit e_dr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit fl, bit dv, logic [6:0] op, logic [5:0] t1, bit r1,
                              logic [5:0] t2, bit r2, bit wv, logic [5:0] wt, bit ir,
                              bit e_iv, logic [3:0] e_idx, logic [4:0] e_cnt, bit e_dr);
    vec_t v;
    v.fl = fl; v.dv = dv; v.op = op; v.t1 = t1; v.r1 = r1; v.t2 = t2; v.r2 = r2;
    v.wv = wv; v.wt = wt; v.ir = ir;
    v.e_iv = e_iv; v.e_idx = e_idx; v.e_cnt = e_cnt; v.e_dr = e_dr;
    return v;
  endfunction

  initial begin
    rst_n = 0; idle();
    disp_op = 0; disp_src1_tag = 0; disp_src2_tag = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
    disp_dst_tag = 0; disp_payload = 0; wakeup_tag = 0;
    m_clear();
    #12;
    chk("reset_count", count, 0);
    chk("reset_disp_ready", disp_ready, 1);
    chk("reset_issue_valid", issue_valid, 0);
    chk("reset_issue_fields", {issue_op, issue_dst_tag, issue_payload, issue_idx}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    //               fl dv op  t1    r1 t2    r2 wv wt    ir  iv idx cnt dr
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    0,  0, 0,  0,  1));
    tbl.push_back(mk(0, 1, 1,  0,    1, 0,    1, 0, 0,    0,  0, 0,  0,  1));
    tbl.push_back(mk(0, 1, 2,  0,    1, 0,    1, 0, 0,    0,  1, 0,  1,  1));
    tbl.push_back(mk(0, 1, 3,  0,    1, 0,    1, 0, 0,    0,  1, 0,  2,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    0,  1, 0,  3,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 0,  3,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 1,  2,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 2,  1,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    0,  0, 0,  0,  1));
    // oldest entry waits on tag 0x15; a younger one issues around it
    tbl.push_back(mk(0, 1, 4,  6'h15,0, 0,    1, 0, 0,    0,  0, 0,  0,  1));
    tbl.push_back(mk(0, 1, 5,  0,    1, 0,    1, 0, 0,    0,  0, 0,  1,  1));
    tbl.push_back(mk(0, 1, 6,  0,    1, 0,    1, 0, 0,    0,  1, 1,  2,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 1,  3,  1));
    tbl.push_back(mk(0, 1, 7,  0,    1, 0,    1, 0, 0,    0,  1, 2,  2,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 1, 6'h15,0,  1, BYP ? 4'd0 : 4'd2, 3, 1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 0,  3,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 2,  2,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    1,  1, 1,  1,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    0,  0, 0,  0,  1));
    // dispatch bypass: src2 tag broadcast in the dispatch cycle
    tbl.push_back(mk(0, 1, 8,  0,    1, 6'h09,0, 1, 6'h09,0,  0, 0,  0,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    0,  1, 0,  1,  1));
    // build count 5, then flush with dispatch and issue firing
    tbl.push_back(mk(0, 1, 9,  0,    1, 0,    1, 0, 0,    0,  1, 0,  1,  1));
    tbl.push_back(mk(0, 1, 10, 0,    1, 0,    1, 0, 0,    0,  1, 0,  2,  1));
    tbl.push_back(mk(0, 1, 11, 0,    1, 0,    1, 0, 0,    0,  1, 0,  3,  1));
    tbl.push_back(mk(0, 1, 12, 0,    1, 0,    1, 0, 0,    0,  1, 0,  4,  1));
    tbl.push_back(mk(1, 1, 13, 0,    1, 0,    1, 0, 0,    1,  1, 0,  5,  1));
    tbl.push_back(mk(0, 0, 0,  0,    0, 0,    0, 0, 0,    0,  0, 0,  0,  1));

    foreach (tbl[k]) begin
      idle();
      flush = tbl[k].fl;
      if (tbl[k].dv) drive_disp(tbl[k].op, tbl[k].t1, tbl[k].r1, tbl[k].t2, tbl[k].r2);
      wakeup_valid = tbl[k].wv; wakeup_tag = tbl[k].wt; issue_ready = tbl[k].ir;
      @(negedge clk);
      chk($sformatf("tbl%0d_iv", k), issue_valid, tbl[k].e_iv);
      chk($sformatf("tbl%0d_idx", k), issue_idx, tbl[k].e_idx);
      chk($sformatf("tbl%0d_cnt", k), count, tbl[k].e_cnt);
      chk($sformatf("tbl%0d_dr", k), disp_ready, tbl[k].e_dr);
      compare_model();
      model_update();
      @(posedge clk); #1;
    end

    // fill to capacity with nothing ready
    idle();
    for (int i = 0; i < 16; i++) begin
      drive_disp(7'(20 + i), 6'h3F, 0, 0, 1);
      step();
    end
    idle();
    @(negedge clk);
    chk("full_disp_ready", disp_ready, 0);
    chk("full_count", count, 16);
    chk("full_issue_valid", issue_valid, 0);
    @(posedge clk); #1;
    drive_disp(7'd99, 0, 1, 0, 1);
    step();
    idle();
    @(negedge clk);
    chk("full_reject_count", count, 16);
    @(posedge clk); #1;
    wakeup_valid = 1; wakeup_tag = 6'h3F;
    step();
    idle(); issue_ready = 1;
    for (int i = 0; i < 3; i++) step();
    idle();

    // asynchronous reset in the middle of a cycle
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_issue_valid", issue_valid, 0);
    chk("async_rst_disp_ready", disp_ready, 1);
    m_clear();
    @(posedge clk); #1;
    rst_n = 1;

    for (int n = 0; n < 3000; n++) begin
      flush        = ($urandom % 64) == 0;
      disp_valid   = ($urandom % 4) != 0;
      disp_op      = 7'($urandom);
      disp_src1_tag = 6'($urandom % 8);
      disp_src2_tag = 6'($urandom % 8);
      disp_src1_rdy = ($urandom % 2) != 0;
      disp_src2_rdy = ($urandom % 2) != 0;
      disp_dst_tag = 6'($urandom);
      disp_payload = $urandom;
      wakeup_valid = ($urandom % 2) != 0;
      wakeup_tag   = 6'($urandom % 8);
      issue_ready  = ($urandom % 3) != 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_queue_sched.md
# issue_queue_sched

Single-issue scheduler for one 16-entry issue queue of the RV64 out-of-order core. Accepts dispatched micro-ops, tracks source-operand readiness through a tag-broadcast wakeup bus, and keeps a dense relative age per entry. Each cycle it issues the oldest fully-ready entry to the execution unit. Sits between rename/dispatch and the functional unit; its age ordering is the same oldest-first policy used by the tree select logic.

## Interface
- DEPTH, 16, number of queue entries (power of two, index width log2(DEPTH)=4)
- OPCODE_WIDTH, 7, micro-op opcode width
- TAG_WIDTH, 6, physical-register tag width
- AGE_WIDTH, 5, age field width (must hold DEPTH-1)
- PAYLOAD_WIDTH, 32, opaque payload (imm/ROB id) carried to issue
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept an entry
- disp_op  in  OPCODE_WIDTH  opcode
- disp_src1_tag, disp_src2_tag  in  TAG_WIDTH  source tags
- disp_src1_rdy, disp_src2_rdy  in  1  source already available
- disp_dst_tag  in  TAG_WIDTH  destination tag
- disp_payload  in  PAYLOAD_WIDTH  payload
- wakeup_valid  in  1  result-tag broadcast valid
- wakeup_tag  in  TAG_WIDTH  broadcast tag
- issue_valid  out  1  an entry is selected
- issue_ready  in  1  execution unit accepts
- issue_op  out  OPCODE_WIDTH; issue_dst_tag  out  TAG_WIDTH; issue_payload  out  PAYLOAD_WIDTH; issue_idx  out  4  selected entry fields/index
- count  out  5  occupied entries (0..16)

## Operation
- Entry state: valid, op, src tags, src rdy bits, dst tag, payload, age. Ready = valid & rdy1 & rdy2.
- Dispatch fires on disp_valid & disp_ready; writes lowest-index free entry.
- Age is a dense rank: 0 = oldest, count-1 = youngest; ages of valid entries are always unique and contiguous.
- New entry age = count, or count-1 if an issue fires the same cycle.
- Issue fires on issue_valid & issue_ready; entry cleared; every remaining entry with age > issued age decrements by 1. Newly dispatched entry is not decremented.
- Selection: among ready entries, smallest age; issue outputs are combinational from the selected entry. Outputs may change while issue_ready is low if an older entry becomes ready.
- Wakeup: every valid entry whose srcN_tag == wakeup_tag sets rdyN. A dispatch in the same cycle whose source tag matches wakeup_tag is written with that rdy bit set (dispatch bypass, always present).
- count: +1 on dispatch, -1 on issue, unchanged when both.
- flush: clears all valid bits and count to 0; overrides dispatch, issue and wakeup in that cycle.

## Timing
- Reset values: all valid = 0, count = 0, disp_ready = 1, issue_valid = 0, issue_op/dst_tag/payload/idx = 0.
- disp_ready = (count != DEPTH), registered-state only; no path from issue_ready (full queue rejects dispatch even if an issue fires that cycle).
- Dispatch in cycle N -> earliest issue cycle N+1.
- Wakeup in cycle N -> entry eligible for issue in cycle N+1 (macro changes this).
- Empty: issue_valid = 0, outputs hold 0. Full: disp_ready = 0.
- Reset asserted mid-operation: all state returns to reset values asynchronously.

## Configuration
- IQ_WAKEUP_BYPASS_EN defined: wakeup matches are also ORed into the readiness used by selection in the same cycle, so an entry waiting only on wakeup_tag can issue in cycle N (zero-cycle wakeup-to-issue).
- Undefined: selection uses registered rdy bits only; wakeup-to-issue is one cycle.

## Test plan
- Reset, dispatch 3 ready ops into empty queue with issue_ready=0 -> count=3, ages 0,1,2 in entries 0,1,2; issue_valid=1, issue_idx=0; disp_ready=1.
- Fill 16 entries with src1_rdy=0 -> disp_ready=0 after 16th, count=16, issue_valid=0; 17th disp_valid ignored.
- Entries ages 0..2, entry age 0 not ready; issue_ready=1 -> entry age 1 issues, remaining ages become 0,1; next dispatch gets age 2.
- Entry waiting on tag 0x15; wakeup_tag=0x15 in cycle N -> issue_valid in N+1 (N with IQ_WAKEUP_BYPASS_EN).
- Dispatch with src2_tag=0x09, src2_rdy=0 while wakeup_tag=0x09 same cycle -> entry stored ready, issues next cycle.
- Queue at count=5, flush with simultaneous disp_valid and issue fire -> count=0, issue_valid=0, disp_ready=1 next cycle.
